debounced_input: RTL and testbench

- Consumes the raw level from a pad-level input buffer (pulled-up pin, idle high) and produces a clean, glitch-free level plus single-cycle edge strobes.
- Synchronizes the asynchronous pin into `clk` and accepts a new level only after it has been stable for a programmable number of cycles.
- Sits directly downstream of the pad input cell and upstream of user logic such as button handlers and mode straps.

---
 rtl/debounced_input_synchronizer.sv | 31 +++
 rtl/debounced_input.sv | 121 ++++++++++++
 tb/tb_debounced_input.sv | 139 +++++++++++++
 3 files changed

// File: rtl/debounced_input_synchronizer.sv
// ----------------------------------------------------------------------------
// synchronizer
// Multi-flop synchronizer that brings an asynchronous level into the clk
// domain. The flops reset to RESET_VALUE so that, coming out of reset, the
// chain already holds the pin's expected idle level. This block can be reused
// for other asynchronous inputs.
// ----------------------------------------------------------------------------
module synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw level through the flop chain; the synchronous reset loads the idle level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RESET_VALUE}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], in};
        end
    end

    assign out = chain_r[STAGES-1];

endmodule

// File: rtl/debounced_input.sv
// ----------------------------------------------------------------------------
// debounced_input
// Synchronizes a pulled-up pad input. A new level is accepted only after the
// synchronized level has differed from the current debounced level for
// DEBOUNCE_CYCLES consecutive cycles. Every accepted transition produces a
// one-cycle rising or falling strobe.
//
// Optional feature: define DEBOUNCED_INPUT_LONGPRESS_EN to build the
// long-press detector. It emits one long_press strobe after the debounced
// level has stayed at ACTIVE_LEVEL for LONGPRESS_CYCLES cycles. When the macro
// is not defined, long_press is tied to 0 and no long-press logic is built.
// ----------------------------------------------------------------------------
module debounced_input #(
    parameter int          SYNC_STAGES      = 2,
    parameter int          DEBOUNCE_CYCLES  = 1000,
    parameter logic        RESET_VALUE      = 1'b1,
    parameter logic        ACTIVE_LEVEL     = 1'b0,
    parameter logic [23:0] LONGPRESS_CYCLES = 24'd12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic value,
    output logic rising,
    output logic falling,
    output logic long_press
);

    // The counter never has to represent DEBOUNCE_CYCLES itself: acceptance
    // happens at DEBOUNCE_CYCLES-1, so $clog2 bits are enough (at least one).
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s_s;
    logic [CNT_W-1:0] cnt_r;
    logic             value_r;
    logic             rising_r;
    logic             falling_r;

    synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (pin),
        .out   (s_s)
    );

    // Qualify the synchronized level: accept it only after an unbroken run of differing cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r   <= RESET_VALUE;
            cnt_r     <= {CNT_W{1'b0}};
            rising_r  <= 1'b0;
            falling_r <= 1'b0;
        end else if (s_s != value_r) begin
            if (cnt_r == CNT_LAST) begin
                value_r   <= s_s;
                cnt_r     <= {CNT_W{1'b0}};
                rising_r  <= s_s;
                falling_r <= ~s_s;
            end else begin
                cnt_r     <= cnt_r + CNT_W'(1);
                rising_r  <= 1'b0;
                falling_r <= 1'b0;
            end
        end else begin
            // Level has returned to the accepted value, so the glitch is discarded
            cnt_r     <= {CNT_W{1'b0}};
            rising_r  <= 1'b0;
            falling_r <= 1'b0;
        end
    end

    assign value   = value_r;
    assign rising  = rising_r;
    assign falling = falling_r;

`ifdef DEBOUNCED_INPUT_LONGPRESS_EN
    localparam int LP_W = $clog2(32'(LONGPRESS_CYCLES) + 32'd1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(32'(LONGPRESS_CYCLES) - 32'd1);

    logic [LP_W-1:0] lp_cnt_r;
    logic            armed_r;
    logic            long_press_r;

    // Time the active level; fire once per press, then saturate until released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lp_cnt_r     <= {LP_W{1'b0}};
            armed_r      <= 1'b0;
            long_press_r <= 1'b0;
        end else if (value_r != ACTIVE_LEVEL) begin
            lp_cnt_r     <= {LP_W{1'b0}};
            armed_r      <= 1'b1;
            long_press_r <= 1'b0;
        end else if (armed_r) begin
            if (lp_cnt_r == LP_LAST) begin
                lp_cnt_r     <= lp_cnt_r + LP_W'(1);
                armed_r      <= 1'b0;
                long_press_r <= 1'b1;
            end else begin
                lp_cnt_r     <= lp_cnt_r + LP_W'(1);
                armed_r      <= 1'b1;
                long_press_r <= 1'b0;
            end
        end else begin
            // Already fired for this press: hold the count and stay quiet
            lp_cnt_r     <= lp_cnt_r;
            armed_r      <= 1'b0;
            long_press_r <= 1'b0;
        end
    end

    assign long_press = long_press_r;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounced_input.sv
// ----------------------------------------------------------------------------
// tb_debounced_input
// Directed bench for debounced_input with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONGPRESS_CYCLES=10. Each step drives pin (and rst_n) before a rising edge,
// pushes the outputs expected after that edge onto a scoreboard queue, then
// pops and compares them 1 time unit after the edge.
// Expected word layout: {value, rising, falling, long_press}.
// ----------------------------------------------------------------------------
module tb_debounced_input;

`ifdef DEBOUNCED_INPUT_LONGPRESS_EN
    localparam logic LP_EN = 1'b1;
`else
    localparam logic LP_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    logic pin;
    logic value;
    logic rising;
    logic falling;
    logic long_press;

    int tests_run;
    int tests_failed;

    sb_entry_t sb_q[$];

    debounced_input #(
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .RESET_VALUE      (1'b1),
        .ACTIVE_LEVEL     (1'b0),
        .LONGPRESS_CYCLES (24'd10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin),
        .value      (value),
        .rising     (rising),
        .falling    (falling),
        .long_press (long_press)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock step: drive, queue expectation, let the edge happen, then check
    task automatic cyc(input string tag, input logic p, input logic [3:0] exp);
        sb_entry_t e;
        sb_entry_t got;
        logic [3:0] obs;
        pin   = p;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        obs = {value, rising, falling, long_press};
        tests_run = tests_run + 1;
        assert (obs === got.exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.exp);
        end
    endtask

    // n steps with a fixed pin level, expecting a steady value and no strobes
    task automatic hold(input string tag, input logic p, input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            cyc(tag, p, {v, 3'b000});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        pin          = 1'b1;

        // Reset state
        cyc("reset0", 1'b1, 4'b1000);
        cyc("reset1", 1'b1, 4'b1000);
        rst_n = 1'b1;

        // Idle after reset release: no strobes for 50 cycles
        hold("idle", 1'b1, 50, 1'b1);

        // 3-low / 1-high bounce bursts never qualify
        for (int b = 0; b < 4; b++) begin
            hold("bounce_low", 1'b0, 3, 1'b1);
            hold("bounce_high", 1'b1, 1, 1'b1);
        end
        hold("bounce_settle", 1'b1, 6, 1'b1);

        // Clean 1->0 step: value changes on the 6th edge that samples the low pin
        hold("fall_wait", 1'b0, 5, 1'b1);
        cyc("fall_edge", 1'b0, 4'b0010);

        // Held low: long_press (if built) fires 10 edges after value fell, once
        hold("lp_wait", 1'b0, 9, 1'b0);
        cyc("lp_edge", 1'b0, {1'b0, 2'b00, LP_EN});
        hold("lp_hold", 1'b0, 30, 1'b0);

        // Clean 0->1 step
        hold("rise_wait", 1'b1, 5, 1'b0);
        cyc("rise_edge", 1'b1, 4'b1100);
        hold("rise_settle", 1'b1, 10, 1'b1);

        // Short re-press (5 low samples): accepted, but too short for long_press
        hold("short_low", 1'b0, 5, 1'b1);
        cyc("short_fall", 1'b1, 4'b0010);
        hold("short_wait", 1'b1, 4, 1'b0);
        cyc("short_rise", 1'b1, 4'b1100);
        hold("short_settle", 1'b1, 20, 1'b1);

        // Reset mid-qualification (counter at 2) discards progress silently
        hold("mid_qual", 1'b0, 4, 1'b1);
        rst_n = 1'b0;
        cyc("mid_reset", 1'b0, 4'b1000);
        rst_n = 1'b1;
        hold("post_reset_wait", 1'b0, 5, 1'b1);
        cyc("post_reset_fall", 1'b0, 4'b0010);
        hold("post_reset_hold", 1'b0, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
